// File: rtl/arty_led_pkg.sv
// Shared widths, button roles and controller states for the Arty LED/button demo.
package arty_led_pkg;

  localparam int LED_W = 4;
  localparam int BTN_W = 4;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;
  localparam int BTN_INV = 3;

  typedef enum logic [1:0] {
    BOOT_HOLD,
    BOOT_WAIT,
    RUN
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-FF synchronizer, stable-level debouncer and a single-cycle press pulse.
module button_debounce
  import arty_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any return to the accepted level restarts the stability window
      if (sync_p1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_MAX) begin
        level      <= sync_p1;
        stable_cnt <= '0;
        press      <= sync_p1;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arty_button_led_ctrl.sv
// Board top: boot phase with all LEDs lit, then a 4-bit up/down/clear/invert counter
// driven by debounced push buttons.
module arty_button_led_ctrl
  import arty_led_pkg::*;
#(
  parameter int BOOT_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             nTRST,
  input  logic             TDI,
  input  logic [BTN_W-1:0] push_buttons_4bits_tri_i,
  output logic [LED_W-1:0] led_4bits_tri_o
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_MAX = BOOT_W'(BOOT_CYCLES - 1);

  logic              tdi_unused;
  logic [BTN_W-1:0]  press;
  logic              ntrst_p0;
  logic              ntrst_p1;
  state_t            state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [LED_W-1:0]  count;
  logic              invert;
  logic [LED_W-1:0]  count_nxt;
  logic              invert_nxt;

  assign tdi_unused = TDI;

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_sys(sys_clock),
      .rst    (reset),
      .btn_raw(push_buttons_4bits_tri_i[i]),
      .press  (press[i])
    );
  end

  // Clear overrides everything; increment beats decrement; invert is independent
  always_comb begin
    count_nxt  = count;
    invert_nxt = invert;
    if (press[BTN_CLR]) begin
      count_nxt  = '0;
      invert_nxt = 1'b0;
    end else begin
      if (press[BTN_INC]) begin
        count_nxt = count + 1'b1;
      end else if (press[BTN_DEC]) begin
        count_nxt = count - 1'b1;
      end
      if (press[BTN_INV]) begin
        invert_nxt = ~invert;
      end
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      ntrst_p0        <= 1'b0;
      ntrst_p1        <= 1'b0;
      state           <= BOOT_HOLD;
      boot_cnt        <= '0;
      count           <= '0;
      invert          <= 1'b0;
      led_4bits_tri_o <= '1;
    end else begin
      ntrst_p0 <= nTRST;
      ntrst_p1 <= ntrst_p0;
      case (state)
        BOOT_HOLD: begin
          led_4bits_tri_o <= '1;
          count           <= '0;
          invert          <= 1'b0;
          boot_cnt        <= '0;
          if (ntrst_p1) begin
            state <= BOOT_WAIT;
          end
        end
        BOOT_WAIT: begin
          led_4bits_tri_o <= '1;
          if (!ntrst_p1) begin
            state <= BOOT_HOLD;
          end else if (boot_cnt == BOOT_MAX) begin
            state           <= RUN;
            led_4bits_tri_o <= count ^ {LED_W{invert}};
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!ntrst_p1) begin
            state           <= BOOT_HOLD;
            led_4bits_tri_o <= '1;
            count           <= '0;
            invert          <= 1'b0;
          end else begin
            count           <= count_nxt;
            invert          <= invert_nxt;
            led_4bits_tri_o <= count_nxt ^ {LED_W{invert_nxt}};
          end
        end
        default: begin
          state           <= BOOT_HOLD;
          led_4bits_tri_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arty_button_led_ctrl.sv
// Directed bench for arty_button_led_ctrl with a scoreboard of expected LED values.
module tb_arty_button_led_ctrl;
  import arty_led_pkg::*;

  localparam int BOOT = 40;
  localparam int DEB  = 8;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       n_trst;
  logic       tdi;
  logic [3:0] btn;
  logic [3:0] led;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb_q[$];
  logic [3:0] m_cnt;
  logic       m_inv;

  always #5 clk_sys = ~clk_sys;

  arty_button_led_ctrl #(
    .BOOT_CYCLES    (BOOT),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .sys_clock               (clk_sys),
    .reset                   (rst),
    .nTRST                   (n_trst),
    .TDI                     (tdi),
    .push_buttons_4bits_tri_i(btn),
    .led_4bits_tri_o         (led)
  );

  initial begin
    tdi = 1'b0;
    forever begin
      @(negedge clk_sys);
      tdi = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat, input int max_lat);
    checks++;
    assert (lat <= max_lat) else begin
      errors++;
      $error("FAIL %s_latency: observed %0d cycles expected <= %0d", tag, lat, max_lat);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] model_led();
    return m_cnt ^ {4{m_inv}};
  endfunction

  // Wait for the LED to reach the oldest queued expectation, then pop and compare
  task automatic await_sb(input string tag, input int bound);
    logic [3:0] exp;
    int lat;
    lat = 0;
    while (led !== sb_q[0] && lat < bound + 3) begin
      @(posedge clk_sys);
      #1;
      lat++;
    end
    exp = sb_q.pop_front();
    check(tag, led, exp);
    check_lat(tag, lat, bound);
  endtask

  task automatic press(input string tag, input logic [3:0] mask);
    if (mask[BTN_CLR]) begin
      m_cnt = 4'h0;
      m_inv = 1'b0;
    end else begin
      if (mask[BTN_INC])      m_cnt = m_cnt + 4'h1;
      else if (mask[BTN_DEC]) m_cnt = m_cnt - 4'h1;
      if (mask[BTN_INV])      m_inv = ~m_inv;
    end
    sb_q.push_back(model_led());
    btn = mask;
    await_sb(tag, DEB + 4);
    cyc(2 * DEB);
    btn = 4'h0;
    cyc(3 * DEB);
    check({tag, "_release"}, led, model_led());
  endtask

  initial begin
    rst    = 1'b1;
    n_trst = 1'b0;
    btn    = 4'h0;
    m_cnt  = 4'h0;
    m_inv  = 1'b0;
    #1;
    check("reset_led", led, 4'hF);
    cyc(500);
    check("reset_led_held", led, 4'hF);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(10);
      check("boot_hold", led, 4'hF);
    end

    n_trst = 1'b1;
    sb_q.push_back(4'h0);
    await_sb("boot_exit", BOOT + 3);

    for (int i = 0; i < 10; i++) press("inc", 4'b0001);
    check("inc_to_a", led, 4'hA);

    for (int i = 0; i < 5; i++) begin
      btn = 4'b0001;
      cyc(DEB / 2);
      btn = 4'b0000;
      cyc(DEB / 2);
    end
    cyc(3 * DEB);
    check("glitch_ignored", led, 4'hA);

    press("clr", 4'b0100);
    for (int i = 0; i < 17; i++) press("inc_wrap", 4'b0001);
    check("wrap_to_1", led, 4'h1);

    press("clr0", 4'b0100);
    press("dec_wrap", 4'b0010);
    press("invert", 4'b1000);
    press("clr_inv", 4'b0100);
    press("inc_dec_same", 4'b0011);
    press("inc_inv", 4'b1001);
    press("clr_beats_inv", 4'b1100);

    n_trst = 1'b0;
    m_cnt  = 4'h0;
    m_inv  = 1'b0;
    sb_q.push_back(4'hF);
    await_sb("ntrst_drop", 4);

    n_trst = 1'b1;
    sb_q.push_back(4'h0);
    cyc(3);
    check("boot_wait_led", led, 4'hF);
    btn = 4'b0001;
    await_sb("reboot_exit", BOOT);
    btn = 4'b0000;
    cyc(3 * DEB);
    check("boot_press_ignored", led, 4'h0);

    for (int i = 0; i < 5; i++) press("inc5", 4'b0001);
    check("count_5", led, 4'h5);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", led, 4'hF);
    cyc(5);
    check("reset_hold2", led, 4'hF);
    rst   = 1'b0;
    m_cnt = 4'h0;
    m_inv = 1'b0;
    sb_q.push_back(4'h0);
    await_sb("post_reset_boot", BOOT + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
